// File: rtl/gpio_bank_mmio.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : gpio_bank_mmio
// Description : Memory-mapped GPIO bank with per-pin direction, atomic
//               set/clear/toggle, synchronised inputs and edge interrupts.
// Revision    : 1.0 - initial release
// ============================================================================
module gpio_bank_mmio #(
  parameter int          WIDTH       = 8,
  parameter logic [31:0] BASE_ADDR   = 32'h2000_0000,
  parameter int          SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      mem_addr,
  input  logic [31:0]      mem_wdata,
  input  logic [3:0]       mem_wmask,
  input  logic             mem_rstrb,
  output logic [31:0]      mem_rdata,
  input  logic [WIDTH-1:0] gpio_in,
  output logic [WIDTH-1:0] gpio_out,
  output logic [WIDTH-1:0] gpio_oe,
  output logic             irq
);

  localparam logic [5:0] C_OFF_DATA_IN  = 6'h00;
  localparam logic [5:0] C_OFF_DATA_OUT = 6'h01;
  localparam logic [5:0] C_OFF_DIR      = 6'h02;
  localparam logic [5:0] C_OFF_OUT_SET  = 6'h03;
  localparam logic [5:0] C_OFF_OUT_CLR  = 6'h04;
  localparam logic [5:0] C_OFF_OUT_TGL  = 6'h05;
  localparam logic [5:0] C_OFF_RISE_EN  = 6'h06;
  localparam logic [5:0] C_OFF_FALL_EN  = 6'h07;
  localparam logic [5:0] C_OFF_IRQ_STAT = 6'h08;

  logic [WIDTH-1:0] r_data_out;
  logic [WIDTH-1:0] r_dir;
  logic [WIDTH-1:0] r_rise_en;
  logic [WIDTH-1:0] r_fall_en;
  logic [WIDTH-1:0] r_irq_stat;
  logic [WIDTH-1:0] r_prev;
  logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync;
  logic             r_irq;

  logic             w_hit;
  logic [5:0]       w_off;
  logic             w_wr;
  logic             w_rd;
  logic [31:0]      w_lane32;
  logic [31:0]      w_wbits32;
  logic [WIDTH-1:0] w_lane;
  logic [WIDTH-1:0] w_wbits;
  logic [WIDTH-1:0] w_sync;
  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_fall;
  logic [WIDTH-1:0] w_w1c;
  logic [WIDTH-1:0] w_data_out_nxt;
  logic [WIDTH-1:0] w_dir_nxt;
  logic [WIDTH-1:0] w_rise_en_nxt;
  logic [WIDTH-1:0] w_fall_en_nxt;
  logic [WIDTH-1:0] w_irq_stat_nxt;
  logic [31:0]      w_rd_val;

  // Address decode: the block owns one 256-byte page.
  assign w_hit = ((mem_addr & 32'hFFFF_FF00) == BASE_ADDR);
  assign w_off = mem_addr[7:2];
  assign w_wr  = w_hit && (mem_wmask != 4'b0000);
  assign w_rd  = w_hit && mem_rstrb;

  // Byte-lane mask; only enabled lanes of wdata ever reach a register.
  assign w_lane32  = {{8{mem_wmask[3]}}, {8{mem_wmask[2]}},
                      {8{mem_wmask[1]}}, {8{mem_wmask[0]}}};
  assign w_wbits32 = mem_wdata & w_lane32;
  assign w_lane    = w_lane32[WIDTH-1:0];
  assign w_wbits   = w_wbits32[WIDTH-1:0];

  generate
    if (WIDTH < 32) begin : g_unused_hi
      logic w_unused_hi;
      assign w_unused_hi = &{1'b0, w_lane32[31:WIDTH], w_wbits32[31:WIDTH]};
    end
  endgenerate

  // Edge detection on the synchronised pin values.
  assign w_sync = r_sync[SYNC_STAGES-1];
  assign w_rise = w_sync & ~r_prev;
  assign w_fall = ~w_sync & r_prev;
  assign w_w1c  = (w_wr && (w_off == C_OFF_IRQ_STAT)) ? w_wbits : '0;

  // New edge flags override a simultaneous write-one-to-clear.
  assign w_irq_stat_nxt = (r_irq_stat & ~w_w1c) | (w_rise & r_rise_en) | (w_fall & r_fall_en);

  // Next-state of the writable registers, honouring byte lanes.
  always_comb begin
    w_data_out_nxt = r_data_out;
    w_dir_nxt      = r_dir;
    w_rise_en_nxt  = r_rise_en;
    w_fall_en_nxt  = r_fall_en;
    if (w_wr) begin
      case (w_off)
        C_OFF_DATA_OUT: w_data_out_nxt = (r_data_out & ~w_lane) | w_wbits;
        C_OFF_OUT_SET:  w_data_out_nxt = r_data_out | w_wbits;
        C_OFF_OUT_CLR:  w_data_out_nxt = r_data_out & ~w_wbits;
        C_OFF_OUT_TGL:  w_data_out_nxt = r_data_out ^ w_wbits;
        C_OFF_DIR:      w_dir_nxt      = (r_dir & ~w_lane) | w_wbits;
        C_OFF_RISE_EN:  w_rise_en_nxt  = (r_rise_en & ~w_lane) | w_wbits;
        C_OFF_FALL_EN:  w_fall_en_nxt  = (r_fall_en & ~w_lane) | w_wbits;
        default: ;
      endcase
    end
  end

  // Read mux over the current (pre-write) register state.
  always_comb begin
    w_rd_val = '0;
    case (w_off)
      C_OFF_DATA_IN:  w_rd_val = 32'(w_sync);
      C_OFF_DATA_OUT: w_rd_val = 32'(r_data_out);
      C_OFF_DIR:      w_rd_val = 32'(r_dir);
      C_OFF_RISE_EN:  w_rd_val = 32'(r_rise_en);
      C_OFF_FALL_EN:  w_rd_val = 32'(r_fall_en);
      C_OFF_IRQ_STAT: w_rd_val = 32'(r_irq_stat);
      default:        w_rd_val = '0;
    endcase
  end

  // Input synchroniser chain and edge-history register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
      r_prev <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], gpio_in};
      r_prev <= w_sync;
    end
  end

  // Control/status registers, registered read data and interrupt line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data_out <= '0;
      r_dir      <= '0;
      r_rise_en  <= '0;
      r_fall_en  <= '0;
      r_irq_stat <= '0;
      r_irq      <= 1'b0;
      mem_rdata  <= '0;
    end else begin
      r_data_out <= w_data_out_nxt;
      r_dir      <= w_dir_nxt;
      r_rise_en  <= w_rise_en_nxt;
      r_fall_en  <= w_fall_en_nxt;
      r_irq_stat <= w_irq_stat_nxt;
      r_irq      <= |r_irq_stat;
      if (w_rd) begin
        mem_rdata <= w_rd_val;
      end
    end
  end

  assign gpio_out = r_data_out;
  assign gpio_oe  = r_dir;
  assign irq      = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_gpio_bank_mmio.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_gpio_bank_mmio
// Description : Self-checking bench for gpio_bank_mmio (WIDTH = 16) with a
//               read-data scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gpio_bank_mmio;

  localparam int          W    = 16;
  localparam logic [31:0] BASE = 32'h2000_0000;

  logic          clk;
  logic          rst_n;
  logic [31:0]   mem_addr;
  logic [31:0]   mem_wdata;
  logic [3:0]    mem_wmask;
  logic          mem_rstrb;
  logic [31:0]   mem_rdata;
  logic [W-1:0]  gpio_in;
  logic [W-1:0]  gpio_out;
  logic [W-1:0]  gpio_oe;
  logic          irq;

  gpio_bank_mmio #(
    .WIDTH      (W),
    .BASE_ADDR  (BASE),
    .SYNC_STAGES(2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask),
    .mem_rstrb(mem_rstrb),
    .mem_rdata(mem_rdata),
    .gpio_in  (gpio_in),
    .gpio_out (gpio_out),
    .gpio_oe  (gpio_oe),
    .irq      (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } rd_exp_t;

  rd_exp_t sb_q[$];
  int      n_checks = 0;
  int      n_fail   = 0;
  logic    rd_pend  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Remember that a read strobe was sampled at this edge.
  always @(posedge clk) rd_pend <= mem_rstrb;

  // Scoreboard monitor: read data is due one edge after the strobe.
  always @(negedge clk) begin
    rd_exp_t e;
    if (rd_pend) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_read: got 0x%08h, expected no read response", mem_rdata);
      end else begin
        e = sb_q.pop_front();
        chk(e.name, mem_rdata, e.exp);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_wr_addr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    @(negedge clk);
    mem_addr  = a;
    mem_wdata = d;
    mem_wmask = m;
    @(posedge clk);
    #1;
    mem_wmask = 4'b0000;
  endtask

  task automatic bus_wr(input logic [5:0] off, input logic [31:0] d, input logic [3:0] m);
    bus_wr_addr(BASE | {24'h0, off, 2'b00}, d, m);
  endtask

  task automatic bus_rd(input logic [5:0] off, input logic [31:0] exp, input string name);
    rd_exp_t e;
    @(negedge clk);
    mem_addr  = BASE | {24'h0, off, 2'b00};
    mem_rstrb = 1'b1;
    e.name = name;
    e.exp  = exp;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    mem_rstrb = 1'b0;
  endtask

  // Simultaneous write and read of the same offset.
  task automatic bus_wrrd(input logic [5:0] off, input logic [31:0] d, input logic [31:0] exp,
                          input string name);
    rd_exp_t e;
    @(negedge clk);
    mem_addr  = BASE | {24'h0, off, 2'b00};
    mem_wdata = d;
    mem_wmask = 4'hF;
    mem_rstrb = 1'b1;
    e.name = name;
    e.exp  = exp;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    mem_wmask = 4'b0000;
    mem_rstrb = 1'b0;
  endtask

  // Watchdog so the run always terminates.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wmask = '0;
    mem_rstrb = 1'b0;
    gpio_in   = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Reset state and reads of every offset
    chk("rst_gpio_out", 32'(gpio_out), 32'h0);
    chk("rst_gpio_oe",  32'(gpio_oe),  32'h0);
    chk("rst_irq",      32'(irq),      32'h0);
    chk("rst_rdata",    mem_rdata,     32'h0);
    for (int i = 0; i <= 10; i++) bus_rd(i[5:0], 32'h0, "rd_reset");
    bus_rd(6'h3F, 32'h0, "rd_reset_hi");

    // Output register and atomic set/clear/toggle
    bus_wr(6'h02, 32'h0000_00FF, 4'hF);
    chk("dir_ff", 32'(gpio_oe), 32'h0000_00FF);
    bus_wr(6'h01, 32'h0000_00A5, 4'hF);
    chk("out_a5", 32'(gpio_out), 32'h0000_00A5);
    bus_wr(6'h03, 32'h0000_0002, 4'hF);
    chk("out_set", 32'(gpio_out), 32'h0000_00A7);
    bus_wr(6'h04, 32'h0000_0080, 4'hF);
    chk("out_clr", 32'(gpio_out), 32'h0000_0027);
    bus_wr(6'h05, 32'h0000_000F, 4'hF);
    chk("out_tgl", 32'(gpio_out), 32'h0000_0028);
    bus_rd(6'h03, 32'h0, "rd_out_set_zero");
    bus_rd(6'h01, 32'h0000_0028, "rd_data_out_28");

    // Byte lanes, width truncation, decode misses, write+read collision
    bus_wr(6'h01, 32'h0000_1234, 4'b0001);
    bus_rd(6'h01, 32'h0000_0034, "rd_lane0");
    bus_wr(6'h02, 32'hFFFF_FFFF, 4'hF);
    bus_rd(6'h02, 32'h0000_FFFF, "rd_dir_trunc");
    chk("oe_ffff", 32'(gpio_oe), 32'h0000_FFFF);
    bus_wr_addr(BASE + 32'h104, 32'h0000_FFFF, 4'hF);
    bus_wr(6'h0A, 32'h0000_FFFF, 4'hF);
    bus_rd(6'h01, 32'h0000_0034, "rd_miss_ignored");
    bus_wr(6'h01, 32'h0000_AB00, 4'b0010);
    bus_rd(6'h01, 32'h0000_AB34, "rd_lane1");
    bus_wrrd(6'h01, 32'h0000_0055, 32'h0000_AB34, "rd_prewrite");
    bus_rd(6'h01, 32'h0000_0055, "rd_postwrite");

    // Rising-edge timing on pin 0 (pin 1 rises but is not enabled)
    bus_wr(6'h06, 32'h0000_0001, 4'hF);
    gpio_in = 16'h0003;
    bus_rd(6'h00, 32'h0, "din_k");
    chk("irq_k", 32'(irq), 32'h0);
    bus_rd(6'h00, 32'h0, "din_k1");
    bus_rd(6'h00, 32'h0000_0003, "din_k2");
    chk("irq_k2", 32'(irq), 32'h0);
    bus_rd(6'h08, 32'h0000_0001, "stat_k3");
    chk("irq_k3", 32'(irq), 32'h1);
    bus_wr(6'h08, 32'h0000_0001, 4'hF);
    chk("irq_w1c_edge", 32'(irq), 32'h1);
    tick();
    chk("irq_w1c_next", 32'(irq), 32'h0);
    bus_rd(6'h08, 32'h0, "stat_cleared");

    // Falling edge on pin 2 coinciding with W1C: set wins
    bus_wr(6'h07, 32'h0000_0004, 4'hF);
    gpio_in[2] = 1'b1;
    repeat (4) tick();
    bus_rd(6'h08, 32'h0, "stat_rise_not_en");
    gpio_in[2] = 1'b0;
    tick();
    tick();
    bus_wr(6'h08, 32'h0000_0004, 4'hF);
    tick();
    chk("irq_set_wins", 32'(irq), 32'h1);
    bus_rd(6'h08, 32'h0000_0004, "stat_set_wins");
    bus_wr(6'h08, 32'h0000_0004, 4'b0010);
    bus_rd(6'h08, 32'h0000_0004, "stat_w1c_wrong_lane");
    bus_wr(6'h08, 32'h0000_0004, 4'b0001);
    tick();
    chk("irq_w1c2", 32'(irq), 32'h0);
    bus_rd(6'h08, 32'h0, "stat_w1c2");

    // Asynchronous reset with pending flags and driven outputs
    bus_wr(6'h06, 32'h0000_0003, 4'hF);
    gpio_in = 16'h0000;
    repeat (4) tick();
    gpio_in = 16'h0003;
    repeat (4) tick();
    bus_rd(6'h08, 32'h0000_0003, "stat_pre_reset");
    bus_wr(6'h01, 32'h0000_00FF, 4'hF);
    chk("out_pre_reset", 32'(gpio_out), 32'h0000_00FF);
    chk("irq_pre_reset", 32'(irq), 32'h1);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_gpio_out", 32'(gpio_out), 32'h0);
    chk("arst_gpio_oe",  32'(gpio_oe),  32'h0);
    chk("arst_irq",      32'(irq),      32'h0);
    chk("arst_rdata",    mem_rdata,     32'h0);
    gpio_in = 16'h0000;
    repeat (2) @(posedge clk);
    gpio_in = 16'h0004;
    repeat (2) @(posedge clk);
    gpio_in = 16'h0003;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    bus_rd(6'h08, 32'h0, "stat_after_reset");
    bus_rd(6'h06, 32'h0, "rise_en_after_reset");
    repeat (3) tick();
    bus_rd(6'h00, 32'h0000_0003, "din_after_reset");
    bus_wr(6'h06, 32'h0000_0003, 4'hF);
    repeat (3) tick();
    bus_rd(6'h08, 32'h0, "no_stale_rise");
    chk("irq_after_reset", 32'(irq), 32'h0);

    repeat (2) tick();
    chk("sb_drained", 32'(sb_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
